// File: rtl/filter_stim_driver.sv
// Stimulus initiator for the sensor/filter protocol: raises Start+Sensor, times the
// Actuator rise, holds Sensor for a programmed time, drops it, times the fall, reports.
module filter_stim_driver #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_hold,
    output logic             start,
    output logic             sensor,
    input  logic             actuator,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] rise_lat,
    output logic [CNT_W-1:0] fall_lat,
    output logic             err_rise,
    output logic             err_fall
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RISE,
        S_HOLD,
        S_FALL,
        S_REPORT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_TOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reset is asserted asynchronously but released on a clock edge.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_int_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   act_s;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = actuator;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign act_s = sync_q[SYNC_STAGES-1];

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] hold_q,     hold_d;
    logic [CNT_W-1:0] rise_lat_q, rise_lat_d;
    logic [CNT_W-1:0] fall_lat_q, fall_lat_d;
    logic             err_rise_q, err_rise_d;
    logic             err_fall_q, err_fall_d;
    logic             accept;

    // A still-high actuator from a previous run would corrupt the next rise latency.
    assign cmd_ready = rst_int_n && (state_q == S_IDLE) && !act_s;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_cnt_d = hold_cnt_q;
        hold_d     = hold_q;
        rise_lat_d = rise_lat_q;
        fall_lat_d = fall_lat_q;
        err_rise_d = err_rise_q;
        err_fall_d = err_fall_q;
        start      = 1'b0;
        sensor     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    hold_d     = cmd_hold;
                    err_rise_d = 1'b0;
                    err_fall_d = 1'b0;
                    cnt_d      = CNT_ZERO;
                    state_d    = S_RISE;
                end
            end

            S_RISE: begin
                start  = 1'b1;
                sensor = 1'b1;
                busy   = 1'b1;
                cnt_d  = cnt_q + CNT_ONE;
                if (act_s) begin
                    rise_lat_d = cnt_q;
                    hold_cnt_d = CNT_ZERO;
                    state_d    = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    // Skip HOLD but still run FALL so Sensor is always left low.
                    err_rise_d = 1'b1;
                    rise_lat_d = CNT_TOUT;
                    cnt_d      = CNT_ZERO;
                    state_d    = S_FALL;
                end
            end

            S_HOLD: begin
                start      = 1'b1;
                sensor     = 1'b1;
                busy       = 1'b1;
                hold_cnt_d = hold_cnt_q + CNT_ONE;
                if (hold_cnt_q == hold_q) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_FALL;
                end
            end

            S_FALL: begin
                busy  = 1'b1;
                cnt_d = cnt_q + CNT_ONE;
                if (!act_s) begin
                    fall_lat_d = cnt_q;
                    state_d    = S_REPORT;
                end else if (cnt_q == CNT_LAST) begin
                    err_fall_d = 1'b1;
                    fall_lat_d = CNT_TOUT;
                    state_d    = S_REPORT;
                end
            end

            S_REPORT: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
            hold_q     <= '0;
            rise_lat_q <= '0;
            fall_lat_q <= '0;
            err_rise_q <= 1'b0;
            err_fall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_cnt_q <= hold_cnt_d;
            hold_q     <= hold_d;
            rise_lat_q <= rise_lat_d;
            fall_lat_q <= fall_lat_d;
            err_rise_q <= err_rise_d;
            err_fall_q <= err_fall_d;
        end
    end

    assign rise_lat = rise_lat_q;
    assign fall_lat = fall_lat_q;
    assign err_rise = err_rise_q;
    assign err_fall = err_fall_q;

endmodule
